// File: rtl/fast_shutter_pkg.sv
// Shared codes for the fast shutter feedback conditioner: FSM states,
// fault reasons and the {in1,in2} sensor code map.
package fast_shutter_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_CLOSED  = 3'd1,
    ST_OPENING = 3'd2,
    ST_OPEN    = 3'd3,
    ST_CLOSING = 3'd4,
    ST_FAULT   = 3'd5
  } pos_state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_INVALID = 2'd1,
    FLT_TIMEOUT = 2'd2
  } fault_code_e;

  // Sensor code is {in1, in2}; in1 is the closed flag, in2 the open flag.
  localparam logic [1:0] SNS_CLOSED  = 2'b10;
  localparam logic [1:0] SNS_OPEN    = 2'b01;
  localparam logic [1:0] SNS_MOVING  = 2'b00;
  localparam logic [1:0] SNS_INVALID = 2'b11;

endpackage

// File: rtl/fast_shutter_fb_debounce.sv
// One raw feedback pin: multi-flop synchroniser followed by a run-length
// debouncer. A level is accepted after DEBOUNCE_CYCLES consecutive samples
// that differ from the current output; a shorter excursion is reported as
// a one-cycle glitch pulse.
module fast_shutter_fb_debounce #(
  parameter int       SYNC_STAGES     = 3,
  parameter int       DEBOUNCE_CYCLES = 1000,
  parameter logic     RST_VAL         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic level_o,
  output logic glitch_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level_q;
  logic [CW-1:0]          run_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, preset to the pin's resting level so reset looks closed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Run counter: count differing samples, flip once the run is long enough.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q <= RST_VAL;
      run_q   <= '0;
    end else if (synced != level_q) begin
      if (run_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= synced;
        run_q   <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end else begin
      run_q <= '0;
    end
  end

  // A run that ends before acceptance is a rejected glitch.
  assign glitch_o = (synced == level_q) && (run_q != '0);
  assign level_o  = level_q;

endmodule

// File: rtl/fast_shutter_fb_cond.sv
// Fast shutter position-feedback conditioner: debounces both sensor pins,
// tracks shutter position, times each travel and latches faults on an
// invalid sensor code or a travel that takes too long.
module fast_shutter_fb_cond
  import fast_shutter_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TRAVEL_TIMEOUT  = 1000000,
  parameter int CNT_W           = 32,
  parameter int GLITCH_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                fast_back_raw1_i,
  input  logic                fast_back_raw2_i,
  input  logic                fault_clr_i,
  output logic                fast_back_in1_o,
  output logic                fast_back_in2_o,
  output logic [2:0]          pos_state_o,
  output logic                fault_o,
  output logic [1:0]          fault_code_o,
  output logic [CNT_W-1:0]    travel_time_o,
  output logic                travel_done_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam int GW1 = GLITCH_W + 1;

  logic in1, in2, glitch1, glitch2;
  logic [1:0] sns;

  fast_shutter_fb_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)
  ) u_deb1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .raw_i(fast_back_raw1_i),
    .level_o(in1), .glitch_o(glitch1)
  );

  fast_shutter_fb_debounce #(
    .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)
  ) u_deb2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .raw_i(fast_back_raw2_i),
    .level_o(in2), .glitch_o(glitch2)
  );

  assign sns = {in1, in2};

  pos_state_e        state_q, state_d;
  logic [CNT_W-1:0]  trv_cnt_q;
  logic [CNT_W-1:0]  travel_time_q;
  logic              done_q;
  logic [1:0]        fault_code_q;
  logic [GLITCH_W-1:0] glitch_q;
  logic [GW1-1:0]    glitch_sum;

  // Decisions made alongside the next state.
  logic ld_one;        // direct end-to-end jump: travel time of one cycle
  logic ld_cnt;        // travel completed: capture the running counter
  logic flt_set;
  logic [1:0] flt_code;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state logic; an invalid code outranks every other event.
  always_comb begin
    state_d  = state_q;
    ld_one   = 1'b0;
    ld_cnt   = 1'b0;
    flt_set  = 1'b0;
    flt_code = FLT_NONE;
    if (state_q != ST_FAULT && sns == SNS_INVALID) begin
      state_d  = ST_FAULT;
      flt_set  = 1'b1;
      flt_code = FLT_INVALID;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sns == SNS_CLOSED)    state_d = ST_CLOSED;
          else if (sns == SNS_OPEN) state_d = ST_OPEN;
        end
        ST_CLOSED: begin
          if (sns == SNS_MOVING) state_d = ST_OPENING;
          else if (sns == SNS_OPEN) begin
            state_d = ST_OPEN;
            ld_one  = 1'b1;
          end
        end
        ST_OPEN: begin
          if (sns == SNS_MOVING) state_d = ST_CLOSING;
          else if (sns == SNS_CLOSED) begin
            state_d = ST_CLOSED;
            ld_one  = 1'b1;
          end
        end
        ST_OPENING: begin
          if (sns == SNS_OPEN) begin
            state_d = ST_OPEN;
            ld_cnt  = 1'b1;
          end else if (sns == SNS_CLOSED) begin
            state_d = ST_CLOSED;
          end else if (trv_cnt_q == CNT_W'(TRAVEL_TIMEOUT)) begin
            state_d  = ST_FAULT;
            flt_set  = 1'b1;
            flt_code = FLT_TIMEOUT;
          end
        end
        ST_CLOSING: begin
          if (sns == SNS_CLOSED) begin
            state_d = ST_CLOSED;
            ld_cnt  = 1'b1;
          end else if (sns == SNS_OPEN) begin
            state_d = ST_OPEN;
          end else if (trv_cnt_q == CNT_W'(TRAVEL_TIMEOUT)) begin
            state_d  = ST_FAULT;
            flt_set  = 1'b1;
            flt_code = FLT_TIMEOUT;
          end
        end
        ST_FAULT: begin
          if (fault_clr_i) state_d = ST_INIT;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Travel counter: load 1 on entering a travel state, then count up and saturate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trv_cnt_q <= '0;
    end else if ((state_d == ST_OPENING || state_d == ST_CLOSING) && state_d != state_q) begin
      trv_cnt_q <= CNT_W'(1);
    end else if ((state_q == ST_OPENING || state_q == ST_CLOSING) && trv_cnt_q != '1) begin
      trv_cnt_q <= trv_cnt_q + 1'b1;
    end
  end

  // Travel result and its one-cycle done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      travel_time_q <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= ld_one | ld_cnt;
      if (ld_one)      travel_time_q <= CNT_W'(1);
      else if (ld_cnt) travel_time_q <= trv_cnt_q;
    end
  end

  // Fault reason: captured on entry to FAULT, cleared when leaving it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                       fault_code_q <= FLT_NONE;
    else if (flt_set)                                   fault_code_q <= flt_code;
    else if (state_q == ST_FAULT && state_d == ST_INIT) fault_code_q <= FLT_NONE;
  end

  // Combined glitch counter; both pins can reject in the same cycle.
  assign glitch_sum = {1'b0, glitch_q} + GW1'(glitch1) + GW1'(glitch2);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                glitch_q <= '0;
    else if (glitch_sum[GLITCH_W]) glitch_q <= '1;
    else                         glitch_q <= glitch_sum[GLITCH_W-1:0];
  end

  // Output decode.
  always_comb begin
    pos_state_o     = state_q;
    fault_o         = (state_q == ST_FAULT);
    fault_code_o    = fault_code_q;
    travel_time_o   = travel_time_q;
    travel_done_o   = done_q;
    glitch_cnt_o    = glitch_q;
    fast_back_in1_o = in1;
    fast_back_in2_o = in2;
  end

endmodule

// File: tb/tb_fast_shutter_fb_cond.sv
// Directed bench for the fast shutter feedback conditioner with a short
// debounce window and timeout so every path is reached quickly.
module tb_fast_shutter_fb_cond;

  localparam int CNT_W    = 32;
  localparam int GLITCH_W = 2;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic                raw1, raw2, clr;
  logic                in1, in2, fault, done;
  logic [2:0]          st;
  logic [1:0]          fcode;
  logic [CNT_W-1:0]    ttime;
  logic [GLITCH_W-1:0] gcnt;

  int tests  = 0;
  int failed = 0;

  fast_shutter_fb_cond #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .TRAVEL_TIMEOUT(50),
    .CNT_W(CNT_W), .GLITCH_W(GLITCH_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .fast_back_raw1_i(raw1), .fast_back_raw2_i(raw2), .fault_clr_i(clr),
    .fast_back_in1_o(in1), .fast_back_in2_o(in2),
    .pos_state_o(st), .fault_o(fault), .fault_code_o(fcode),
    .travel_time_o(ttime), .travel_done_o(done), .glitch_cnt_o(gcnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; raw1 = 1'b1; raw2 = 1'b0; clr = 1'b0;
    #3;
    tick(); tick();
    tests++;
    if ({in1, in2} !== 2'b10) begin failed++; $display("FAIL reset_pins got %b want 10", {in1, in2}); end
    tests++;
    if (st !== 3'd0 || fault !== 1'b0 || fcode !== 2'd0) begin
      failed++; $display("FAIL reset_state st=%0d fault=%b code=%0d want 0/0/0", st, fault, fcode);
    end
    tests++;
    if (ttime !== '0 || done !== 1'b0 || gcnt !== '0) begin
      failed++; $display("FAIL reset_counters time=%0d done=%b glitch=%0d want 0", ttime, done, gcnt);
    end
    rst_n_i = 1'b1;
    tests++;
    if (st !== 3'd0) begin failed++; $display("FAIL init_hold st=%0d want 0", st); end
    tick();
    tests++;
    if (st !== 3'd1) begin failed++; $display("FAIL init_to_closed st=%0d want 1", st); end
  endtask

  task automatic test_glitch();
    logic bad;
    bad = 1'b0;
    raw1 = 1'b0;
    tick(); tick();
    raw1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (in1 !== 1'b1 || in2 !== 1'b0 || st !== 3'd1) bad = 1'b1;
    end
    tests++;
    if (bad) begin failed++; $display("FAIL glitch_pins_stable got in=%b%b st=%0d want 10 st=1", in1, in2, st); end
    tests++;
    if (gcnt !== 2'd1) begin failed++; $display("FAIL glitch_count got %0d want 1", gcnt); end
  endtask

  task automatic test_open();
    raw1 = 1'b0; raw2 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) begin
        tests++;
        if (in1 !== 1'b1) begin failed++; $display("FAIL deb_early got in1=%b want 1", in1); end
      end
      if (i == 6) begin
        tests++;
        if (in1 !== 1'b0 || st !== 3'd1) begin
          failed++; $display("FAIL deb_latency got in1=%b st=%0d want 0/1", in1, st);
        end
      end
      if (i == 7) begin
        tests++;
        if (st !== 3'd2) begin failed++; $display("FAIL opening got st=%0d want 2", st); end
      end
    end
    raw2 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 6) begin
        tests++;
        if (in2 !== 1'b1 || st !== 3'd2 || done !== 1'b0) begin
          failed++; $display("FAIL open_arrive got in2=%b st=%0d done=%b want 1/2/0", in2, st, done);
        end
      end
      if (j == 7) begin
        tests++;
        if (st !== 3'd3 || done !== 1'b1 || ttime !== 32'd10) begin
          failed++; $display("FAIL open_done got st=%0d done=%b time=%0d want 3/1/10", st, done, ttime);
        end
      end
      if (j == 8) begin
        tests++;
        if (done !== 1'b0) begin failed++; $display("FAIL done_pulse_width got %b want 0", done); end
      end
    end
  endtask

  task automatic test_timeout();
    raw2 = 1'b0;
    for (int i = 1; i <= 57; i++) begin
      tick();
      if (i == 7) begin
        tests++;
        if (st !== 3'd4) begin failed++; $display("FAIL closing got st=%0d want 4", st); end
      end
      if (i == 56) begin
        tests++;
        if (st !== 3'd4 || fault !== 1'b0) begin
          failed++; $display("FAIL pre_timeout got st=%0d fault=%b want 4/0", st, fault);
        end
      end
    end
    tests++;
    if (st !== 3'd5 || fault !== 1'b1 || fcode !== 2'd2) begin
      failed++; $display("FAIL timeout got st=%0d fault=%b code=%0d want 5/1/2", st, fault, fcode);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++;
    if (st !== 3'd0 || fault !== 1'b0 || fcode !== 2'd0 || ttime !== 32'd10) begin
      failed++; $display("FAIL clr_timeout got st=%0d fault=%b code=%0d time=%0d want 0/0/0/10", st, fault, fcode, ttime);
    end
    tick(); tick(); tick();
    tests++;
    if (st !== 3'd0) begin failed++; $display("FAIL init_moving got st=%0d want 0", st); end
  endtask

  task automatic test_invalid();
    raw1 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (st !== 3'd1) begin failed++; $display("FAIL init_closed got st=%0d want 1", st); end
    raw2 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (st !== 3'd1 || {in1, in2} !== 2'b11) begin
      failed++; $display("FAIL pre_invalid got st=%0d in=%b%b want 1/11", st, in1, in2);
    end
    tick();
    tests++;
    if (st !== 3'd5 || fault !== 1'b1 || fcode !== 2'd1) begin
      failed++; $display("FAIL invalid got st=%0d fault=%b code=%0d want 5/1/1", st, fault, fcode);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++;
    if (st !== 3'd0 || fault !== 1'b0 || fcode !== 2'd0) begin
      failed++; $display("FAIL clr_invalid got st=%0d fault=%b code=%0d want 0/0/0", st, fault, fcode);
    end
    tick();
    tests++;
    if (st !== 3'd5 || fault !== 1'b1 || fcode !== 2'd1) begin
      failed++; $display("FAIL refault got st=%0d fault=%b code=%0d want 5/1/1", st, fault, fcode);
    end
  endtask

  task automatic test_reset_mid_travel();
    logic saw_done;
    saw_done = 1'b0;
    raw2 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    tests++;
    if (st !== 3'd1) begin failed++; $display("FAIL recover_closed got st=%0d want 1", st); end
    raw1 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (st !== 3'd2) begin failed++; $display("FAIL mid_opening got st=%0d want 2", st); end
    rst_n_i = 1'b0;
    #1;
    tests++;
    if (st !== 3'd0 || {in1, in2} !== 2'b10 || ttime !== '0 || done !== 1'b0 || fault !== 1'b0) begin
      failed++; $display("FAIL async_reset got st=%0d in=%b%b time=%0d done=%b fault=%b want 0/10/0/0/0",
                         st, in1, in2, ttime, done, fault);
    end
    raw1 = 1'b1;
    tick(); tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    tests++;
    if (saw_done || st !== 3'd1) begin
      failed++; $display("FAIL post_reset got done_seen=%b st=%0d want 0/1", saw_done, st);
    end
  endtask

  task automatic test_glitch_sat();
    // Both pins excursion together for two cycles: two rejections at once.
    raw1 = 1'b0; raw2 = 1'b1;
    tick(); tick();
    raw1 = 1'b1; raw2 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (gcnt !== 2'd2) begin failed++; $display("FAIL glitch_dual got %0d want 2", gcnt); end
    raw1 = 1'b0; raw2 = 1'b1;
    tick(); tick();
    raw1 = 1'b1; raw2 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (gcnt !== 2'd3) begin failed++; $display("FAIL glitch_sat_dual got %0d want 3", gcnt); end
    raw1 = 1'b0;
    tick(); tick();
    raw1 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (gcnt !== 2'd3 || st !== 3'd1) begin
      failed++; $display("FAIL glitch_sat_hold got cnt=%0d st=%0d want 3/1", gcnt, st);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tick();
    tests++;
    if (st !== 3'd1 || fault !== 1'b0) begin
      failed++; $display("FAIL clr_ignored got st=%0d fault=%b want 1/0", st, fault);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_open();
    test_timeout();
    test_invalid();
    test_reset_mid_travel();
    test_glitch_sat();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fast_shutter_fb_cond.md
Name: fast_shutter_fb_cond

Overview:
Conditions the two raw optical position-feedback pins of the fast shutter before they reach fast_shutter_ctrl, which sits directly downstream. Per pin: synchronise, then debounce. Decodes the debounced pair into a position state machine, measures open/close travel time, counts rejected glitches, and raises a sticky fault on invalid sensor codes or travel timeout. Filtered pins drive fast_shutter_ctrl's fast_back_in1_i/fast_back_in2_i.

Parameters:
SYNC_STAGES, 3, synchroniser flops per raw pin (min 2)
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new pin level (min 2)
TRAVEL_TIMEOUT, 1000000, max cycles allowed in OPENING/CLOSING before fault
CNT_W, 32, width of travel_time_o and of the internal travel counter
GLITCH_W, 16, width of glitch_cnt_o

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
fast_back_raw1_i  in  1  raw sensor 1 (1 = closed flag), asynchronous
fast_back_raw2_i  in  1  raw sensor 2 (1 = open flag), asynchronous
fault_clr_i  in  1  single-cycle pulse, clears sticky fault
fast_back_in1_o  out  1  debounced sensor 1, to fast_shutter_ctrl
fast_back_in2_o  out  1  debounced sensor 2, to fast_shutter_ctrl
pos_state_o  out  3  current FSM state code
fault_o  out  1  sticky fault flag
fault_code_o  out  2  0 none, 1 invalid code 11, 2 travel timeout
travel_time_o  out  CNT_W  cycles of the last completed travel
travel_done_o  out  1  one-cycle pulse when travel_time_o updates
glitch_cnt_o  out  GLITCH_W  saturating count of rejected pulses, both pins combined

Behaviour:
- Reset (async assert, sync release): synchronisers and debounced outputs preset to in1=1, in2=0 (closed). pos_state_o=INIT, fault_o=0, fault_code_o=0, travel_time_o=0, travel_done_o=0, glitch_cnt_o=0.
- Debounce, per pin: a run counter increments while the synced level differs from the debounced level. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears. If the synced level returns to the debounced level earlier, the counter clears and the glitch counter increments, saturating at all-ones.
- Latency: a clean raw edge appears on fast_back_inX_o exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks after the first sampling edge. The FSM reacts one clock later.
- Glitches rejected on both pins in the same cycle increment glitch_cnt_o by 2, still saturating.
- Sensor code {in1,in2}: 10 = closed, 01 = open, 00 = moving, 11 = invalid.
- FSM codes: INIT=0, CLOSED=1, OPENING=2, OPEN=3, CLOSING=4, FAULT=5.
- INIT: on the first cycle after reset release, go to CLOSED on 10, OPEN on 01, FAULT on 11; stay on 00.
- CLOSED: on 00 go to OPENING; on 01 go to OPEN with travel_time=1 and a done pulse.
- OPEN: on 00 go to CLOSING; on 10 go to CLOSED with travel_time=1 and a done pulse.
- OPENING/CLOSING: the travel counter loads 1 on entry and increments each cycle.
  - Reaching the target code (01 / 10): latch the counter into travel_time_o, pulse travel_done_o, enter OPEN/CLOSED.
  - Returning to the origin code: enter that state with no latch and no pulse.
  - Counter equal to TRAVEL_TIMEOUT: FAULT with code 2.
- In any non-FAULT state, code 11 goes to FAULT with code 1. Code 11 has priority over a same-cycle timeout.
- FAULT: outputs hold. fault_o=1 until fault_clr_i, then INIT on the next cycle with fault_o/fault_code_o cleared. travel_time_o and glitch_cnt_o are retained.
- fault_clr_i outside FAULT is ignored.
- The travel counter saturates at 2^CNT_W-1.
- Reset mid-travel aborts without a done pulse.

Decomposition:
- Package fast_shutter_pkg: FSM state codes, fault codes, sensor code constants (SNS_CLOSED=2'b10, SNS_OPEN=2'b01, SNS_MOVING=2'b00, SNS_INVALID=2'b11).
- Sub-module fast_shutter_fb_debounce (params SYNC_STAGES, DEBOUNCE_CYCLES, RST_VAL): one synchroniser plus debouncer, outputs a level and a glitch pulse. Instantiated twice, RST_VAL=1 for pin 1 and 0 for pin 2.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TRAVEL_TIMEOUT=50):
- Reset with raw=10 → outputs 10; pos_state 0 then 1; all counters 0.
- Raw 10→00 for 10 cycles, then 01 → in1 falls 6 clocks after the edge; OPENING then OPEN; travel_done pulse with travel_time_o=10.
- Pulse raw1 low for 2 cycles while CLOSED → outputs unchanged; glitch_cnt_o=1; state stays CLOSED.
- Raw held at 00 after OPEN → CLOSING; at count 50 enters FAULT, fault_code_o=2; fault_clr_i pulse → INIT next cycle; FSM stays in INIT while code is 00.
- Raw 11 stable while CLOSED → FAULT, fault_code_o=1; clr with raw still 11 → INIT then FAULT again.
- Assert rst_n_i mid-OPENING → immediate reset values, no travel_done pulse; glitch saturation test with GLITCH_W=2 → holds at 3.
